// File: rtl/ahb_lite_fir_slave_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : ahb_lite_fir_slave_fifo_if
// Brief   : AHB-Lite bus signal bundle for the FIR slave (master/slave views)
// Revision: 1.0
// ============================================================================
interface ahb_lite_fir_slave_fifo_if #(
    parameter int ADDR_W = 5
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [2:0]        hsize;
    logic [1:0]        htrans;
    logic              hwrite;
    logic              hready;
    logic [15:0]       hwdata;
    logic [15:0]       hrdata;
    logic              hreadyout;
    logic              hresp;

    modport master (
        output hsel, haddr, hsize, htrans, hwrite, hready, hwdata,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, hsize, htrans, hwrite, hready, hwdata,
        output hrdata, hreadyout, hresp
    );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_fir_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ahb_lite_fir_slave_fifo
// Brief   : AHB-Lite register slave with sample FIFO feeding a FIR controller
// Revision: 1.0
// ============================================================================
module ahb_lite_fir_slave_fifo #(
    parameter int NUM_COEFFS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    ahb_lite_fir_slave_fifo_if.slave      bus,
    input  logic                          i_modwait,
    input  logic [15:0]                   i_fir_out,
    input  logic                          i_err,
    input  logic [$clog2(NUM_COEFFS)-1:0] i_coefficient_num,
    input  logic                          i_coeff_ack,
    output logic [15:0]                   o_sample_data,
    output logic                          o_data_ready,
    output logic                          o_new_coefficient_set,
    output logic [15:0]                   o_fir_coefficient
);

    localparam int CW = $clog2(NUM_COEFFS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam int IW = ADDR_W - 1;

    // Register index = halfword address (byte address >> 1)
    localparam logic [IW-1:0] c_IDX_STATUS   = IW'(0);
    localparam logic [IW-1:0] c_IDX_RESULT   = IW'(1);
    localparam logic [IW-1:0] c_IDX_SAMPLE   = IW'(2);
    localparam logic [IW-1:0] c_IDX_CTRL     = IW'(3);
    localparam logic [IW-1:0] c_IDX_COUNT    = IW'(4);
    localparam logic [IW-1:0] c_IDX_COEFF_LO = IW'(8);
    localparam logic [IW-1:0] c_IDX_COEFF_HI = IW'(8 + NUM_COEFFS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_dp_valid;
    logic             r_dp_write;
    logic [ADDR_W-1:0] r_dp_addr;
    logic [2:0]       r_dp_size;
    logic             r_err2;

    logic [15:0]      r_coeff [NUM_COEFFS];
    logic [15:0]      r_mem   [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [NW-1:0]    r_count;
    logic             r_ncs;
    logic [15:0]      r_sample;

    logic [IW-1:0]    w_idx;
    logic [CW-1:0]    w_coeff_sel;
    logic             w_is_coeff;
    logic             w_mapped;
    logic             w_ro;
    logic             w_bad;
    logic             w_dp_err;
    logic             w_lo_en;
    logic             w_hi_en;
    logic             w_sample_req;
    logic             w_stall;
    logic             w_wr_go;
    logic             w_push;
    logic             w_pop;
    logic             w_ctrl_wr;
    logic             w_flush;
    logic             w_ncs_set;
    logic             w_empty;
    logic             w_full;
    logic             w_busy;
    logic             w_load_sample;
    logic             w_data_ready;
    logic [15:0]      w_push_data;
    logic [15:0]      w_rdata;
    logic [15:0]      w_coeff_pad [2**CW];
    logic             w_unused;

    assign w_unused = bus.htrans[0];

    // ------------------------------------------------------------------
    // Address phase capture; held while the data phase is being stretched
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
            r_dp_size  <= 3'd0;
            r_err2     <= 1'b0;
        end else begin
            if (bus.hready) begin
                r_dp_valid <= bus.hsel && bus.htrans[1];
                r_dp_write <= bus.hwrite;
                r_dp_addr  <= bus.haddr;
                r_dp_size  <= bus.hsize;
            end
            r_err2 <= w_dp_err && !r_err2;
        end
    end

    // ------------------------------------------------------------------
    // Data phase decode
    // ------------------------------------------------------------------
    assign w_idx        = r_dp_addr[ADDR_W-1:1];
    assign w_coeff_sel  = r_dp_addr[CW:1];
    assign w_is_coeff   = (w_idx >= c_IDX_COEFF_LO) && (w_idx <= c_IDX_COEFF_HI);
    assign w_mapped     = w_is_coeff || (w_idx <= c_IDX_COUNT);
    assign w_ro         = (w_idx == c_IDX_STATUS) || (w_idx == c_IDX_RESULT) ||
                          (w_idx == c_IDX_COUNT);
    assign w_bad        = !w_mapped || (r_dp_write && w_ro) || (r_dp_size > 3'd1) ||
                          ((r_dp_size == 3'd1) && r_dp_addr[0]);
    assign w_dp_err     = r_dp_valid && w_bad;
    assign w_lo_en      = r_dp_size[0] || !r_dp_addr[0];
    assign w_hi_en      = r_dp_size[0] || r_dp_addr[0];

    // A full FIFO only stalls the push when no entry leaves this cycle
    assign w_sample_req = r_dp_valid && r_dp_write && !w_bad && (w_idx == c_IDX_SAMPLE);
    assign w_stall      = w_sample_req && w_full && !w_pop;
    assign w_wr_go      = r_dp_valid && r_dp_write && !w_bad && !w_stall;
    assign w_push       = w_wr_go && (w_idx == c_IDX_SAMPLE);
    assign w_ctrl_wr    = w_wr_go && (w_idx == c_IDX_CTRL) && w_lo_en;
    assign w_flush      = w_ctrl_wr && bus.hwdata[1];
    assign w_ncs_set    = w_ctrl_wr && bus.hwdata[0];
    assign w_push_data  = {w_hi_en ? bus.hwdata[15:8] : 8'h00,
                           w_lo_en ? bus.hwdata[7:0]  : 8'h00};

    assign bus.hreadyout = !(w_dp_err && !r_err2) && !w_stall;
    assign bus.hresp     = w_dp_err;
    assign bus.hrdata    = w_rdata;

    // ------------------------------------------------------------------
    // Coefficient registers with byte lanes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_COEFFS; k++) begin
                r_coeff[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < NUM_COEFFS; k++) begin
                if (w_wr_go && w_is_coeff && (w_coeff_sel == CW'(k))) begin
                    if (w_lo_en) r_coeff[k][7:0]  <= bus.hwdata[7:0];
                    if (w_hi_en) r_coeff[k][15:8] <= bus.hwdata[15:8];
                end
            end
        end
    end

    // Pad to a power of two so out-of-range indices read as zero
    for (genvar j = 0; j < 2**CW; j++) begin : g_coeff_pad
        if (j < NUM_COEFFS) begin : g_real
            assign w_coeff_pad[j] = r_coeff[j];
        end else begin : g_zero
            assign w_coeff_pad[j] = 16'h0000;
        end
    end

    assign o_fir_coefficient = w_coeff_pad[i_coefficient_num];

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    assign w_empty = (r_count == NW'(0));
    assign w_full  = (r_count == NW'(FIFO_DEPTH));
    assign w_pop   = (r_state == S_ISSUE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Coefficient reload flag: a new set request beats a simultaneous ack
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ncs <= 1'b0;
        end else if (w_ncs_set) begin
            r_ncs <= 1'b1;
        end else if (i_coeff_ack) begin
            r_ncs <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Feeder FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_sample = 1'b0;
        w_data_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !i_modwait && !r_ncs) begin
                    w_state_nxt   = S_ISSUE;
                    w_load_sample = 1'b1;
                end
            end
            S_ISSUE: begin
                w_data_ready = 1'b1;
                w_state_nxt  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (i_modwait) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!i_modwait) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample <= 16'h0000;
        end else if (w_load_sample) begin
            r_sample <= r_mem[r_rptr];
        end
    end

    assign o_sample_data         = r_sample;
    assign o_data_ready          = w_data_ready;
    assign o_new_coefficient_set = r_ncs;
    assign w_busy                = i_modwait || r_ncs || (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Read mux, driven only during a legal read data phase
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 16'h0000;
        if (r_dp_valid && !r_dp_write && !w_bad) begin
            if (w_is_coeff) begin
                w_rdata = w_coeff_pad[w_coeff_sel];
            end else begin
                case (w_idx)
                    c_IDX_STATUS: w_rdata = {7'd0, i_err, 5'd0, w_full, w_empty, w_busy};
                    c_IDX_RESULT: w_rdata = i_fir_out;
                    c_IDX_SAMPLE: w_rdata = w_empty ? 16'h0000 : r_mem[r_rptr];
                    c_IDX_COUNT:  w_rdata = 16'(r_count);
                    default:      w_rdata = 16'h0000;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_fir_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_lite_fir_slave_fifo
// Brief   : Self-checking bench for the AHB-Lite FIR slave with sample FIFO
// Revision: 1.0
// ============================================================================
module tb_ahb_lite_fir_slave_fifo;
    localparam int NUM_COEFFS = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        modwait;
    logic        hold_busy;
    logic        ctrl_busy;
    logic [15:0] fir_out;
    logic        err;
    logic [1:0]  coefficient_num;
    logic        coeff_ack;
    logic [15:0] sample_data;
    logic        data_ready;
    logic        new_coefficient_set;
    logic [15:0] fir_coefficient;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_coeff [NUM_COEFFS];
    logic [15:0] m_q[$];
    logic [15:0] got_q[$];

    ahb_lite_fir_slave_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    // Single-slave bus: the global ready is this slave's ready
    assign bus.hready = bus.hreadyout;
    assign modwait    = hold_busy | ctrl_busy;

    always #5 clk = ~clk;

    ahb_lite_fir_slave_fifo #(
        .NUM_COEFFS(NUM_COEFFS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .i_modwait            (modwait),
        .i_fir_out            (fir_out),
        .i_err                (err),
        .i_coefficient_num    (coefficient_num),
        .i_coeff_ack          (coeff_ack),
        .o_sample_data        (sample_data),
        .o_data_ready         (data_ready),
        .o_new_coefficient_set(new_coefficient_set),
        .o_fir_coefficient    (fir_coefficient)
    );

    // FIR controller stand-in: log each issued sample, then stay busy a while
    initial begin
        ctrl_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (data_ready === 1'b1) begin
                got_q.push_back(sample_data);
                ctrl_busy = 1'b1;
                repeat ($urandom_range(2, 4)) @(negedge clk);
                ctrl_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One non-pipelined transfer; resp/rdy capture the first two data-phase cycles
    task automatic xfer(input logic wr, input logic [4:0] a, input logic [2:0] sz,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output logic [1:0] resp, output logic [1:0] rdy, output int n);
        @(negedge clk);
        bus.hsel = 1'b1; bus.haddr = a; bus.hsize = sz; bus.htrans = 2'b10; bus.hwrite = wr;
        @(negedge clk);
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = wd;
        #1;
        n = 0; resp = 2'b00; rdy = 2'b00;
        while (bus.hreadyout !== 1'b1 && n < 50) begin
            if (n < 2) begin resp[n] = bus.hresp; rdy[n] = 1'b0; end
            @(negedge clk); #1;
            n++;
        end
        if (n < 2) begin resp[n] = bus.hresp; rdy[n] = bus.hreadyout; end
        rd = bus.hrdata;
    endtask

    task automatic wr16(input logic [4:0] a, input logic [15:0] v);
        logic [15:0] rd; logic [1:0] rs, ry; int n;
        xfer(1'b1, a, 3'd1, v, rd, rs, ry, n);
    endtask

    task automatic rd16(input logic [4:0] a, output logic [15:0] v);
        logic [1:0] rs, ry; int n;
        xfer(1'b0, a, 3'd1, 16'h0000, v, rs, ry, n);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b1; hold_busy = 1'b0; fir_out = 16'h0; err = 1'b0;
        coefficient_num = 2'd0; coeff_ack = 1'b0;
        bus.hsel = 1'b0; bus.haddr = '0; bus.hsize = 3'd0; bus.htrans = 2'b00;
        bus.hwrite = 1'b0; bus.hwdata = 16'h0;
        for (int k = 0; k < NUM_COEFFS; k++) m_coeff[k] = 16'h0;
        #2;
        checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b want 1", bus.hreadyout); end
        checks++; if (bus.hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", bus.hresp); end
        checks++; if (bus.hrdata !== 16'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0000", bus.hrdata); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
        checks++; if (sample_data !== 16'h0) begin errors++; $display("FAIL reset_sample_data: got %h want 0000", sample_data); end
        checks++; if (new_coefficient_set !== 1'b0) begin errors++; $display("FAIL reset_ncs: got %b want 0", new_coefficient_set); end
        checks++; if (fir_coefficient !== 16'h0) begin errors++; $display("FAIL reset_fir_coeff: got %h want 0000", fir_coefficient); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd16(5'h00, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL reset_status: got %h want 0002", v); end
        rd16(5'h08, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", v); end
    endtask

    task automatic test_status_result();
        logic [15:0] v, rd, f; logic [1:0] rs, ry; int n;
        for (int i = 0; i < 3; i++) begin
            f = 16'($urandom);
            fir_out = f;
            rd16(5'h02, v);
            checks++; if (v !== f) begin errors++; $display("FAIL result_read: got %h want %h", v, f); end
        end
        err = 1'b1;
        rd16(5'h00, v);
        checks++; if (v !== 16'h0102) begin errors++; $display("FAIL status_err: got %h want 0102", v); end
        err = 1'b0;
        xfer(1'b1, 5'h10, 3'd1, 16'h5A5A, rd, rs, ry, n);
        m_coeff[0] = 16'h5A5A;
        checks++; if (rd !== 16'h0) begin errors++; $display("FAIL hrdata_on_write: got %h want 0000", rd); end
    endtask

    task automatic test_coeff();
        logic [15:0] pat [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        logic [15:0] v;
        for (int k = 0; k < NUM_COEFFS; k++) begin
            wr16(5'(16 + 2 * k), pat[k]);
            m_coeff[k] = pat[k];
        end
        @(negedge clk);
        for (int k = 0; k < NUM_COEFFS; k++) begin
            coefficient_num = 2'(k);
            #1;
            checks++; if (fir_coefficient !== m_coeff[k]) begin errors++; $display("FAIL coeff_sweep[%0d]: got %h want %h", k, fir_coefficient, m_coeff[k]); end
        end
        for (int k = 0; k < NUM_COEFFS; k++) begin
            v = 16'($urandom);
            wr16(5'(16 + 2 * k), v);
            m_coeff[k] = v;
        end
        for (int k = 0; k < NUM_COEFFS; k++) begin
            rd16(5'(16 + 2 * k), v);
            checks++; if (v !== m_coeff[k]) begin errors++; $display("FAIL coeff_readback[%0d]: got %h want %h", k, v, m_coeff[k]); end
        end
    endtask

    task automatic test_byte_write();
        logic [15:0] v, rd, wd; logic [1:0] rs, ry; int n, k, hi; logic [7:0] b, junk;
        wr16(5'h10, 16'h1234);
        m_coeff[0] = 16'h1234;
        xfer(1'b1, 5'h11, 3'd0, 16'hAB00, rd, rs, ry, n);
        m_coeff[0] = 16'hAB34;
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL byte_write_hresp: got %b want 00", rs); end
        rd16(5'h10, v);
        checks++; if (v !== 16'hAB34) begin errors++; $display("FAIL byte_write_ab34: got %h want ab34", v); end
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, NUM_COEFFS - 1);
            hi = $urandom_range(0, 1);
            b = 8'($urandom); junk = 8'($urandom);
            wd = (hi == 1) ? {b, junk} : {junk, b};
            xfer(1'b1, 5'(16 + 2 * k + hi), 3'd0, wd, rd, rs, ry, n);
            if (hi == 1) m_coeff[k][15:8] = b; else m_coeff[k][7:0] = b;
            rd16(5'(16 + 2 * k), v);
            checks++; if (v !== m_coeff[k]) begin errors++; $display("FAIL byte_write_rand[%0d]: got %h want %h", i, v, m_coeff[k]); end
        end
    endtask

    task automatic test_errors();
        logic [4:0]  ea [6] = '{5'h02, 5'h05, 5'h12, 5'h0A, 5'h18, 5'h00};
        logic [2:0]  es [6] = '{3'd1,  3'd1,  3'd2,  3'd1,  3'd1,  3'd0};
        logic        ew [6] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
        logic [15:0] v, rd; logic [1:0] rs, ry; int n;
        for (int i = 0; i < 6; i++) begin
            xfer(ew[i], ea[i], es[i], 16'hFFFF, rd, rs, ry, n);
            checks++; if (rs !== 2'b11 || ry !== 2'b10) begin errors++; $display("FAIL error_resp[%0d]: got hresp=%b hreadyout=%b want 11/10 (cyc1 in bit0)", i, rs, ry); end
        end
        rd16(5'h12, v);
        checks++; if (v !== m_coeff[1]) begin errors++; $display("FAIL error_coeff_kept: got %h want %h", v, m_coeff[1]); end
        rd16(5'h08, v);
        checks++; if (v !== 16'h0) begin errors++; $display("FAIL error_fifo_kept: got %h want 0000", v); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v; logic [4:0] a; int k;
        for (int i = 0; i < 3; i++) begin
            k = $urandom_range(0, NUM_COEFFS - 1);
            a = 5'(16 + 2 * k);
            v = 16'($urandom);
            @(negedge clk);
            bus.hsel = 1'b1; bus.haddr = a; bus.hsize = 3'd1; bus.htrans = 2'b10; bus.hwrite = 1'b1;
            @(negedge clk);
            bus.hwdata = v; bus.hwrite = 1'b0;
            @(negedge clk);
            bus.hsel = 1'b0; bus.htrans = 2'b00;
            m_coeff[k] = v;
            #1;
            checks++; if (bus.hrdata !== v || bus.hreadyout !== 1'b1) begin errors++; $display("FAIL back_to_back[%0d]: got %h ready=%b want %h ready=1", i, bus.hrdata, bus.hreadyout, v); end
        end
    endtask

    task automatic test_fifo_stall();
        logic [15:0] v, rd; logic [1:0] rs, ry; int n;
        hold_busy = 1'b1;
        got_q.delete(); m_q.delete();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            v = 16'($urandom);
            wr16(5'h04, v);
            m_q.push_back(v);
        end
        rd16(5'h08, v);
        checks++; if (v !== 16'(FIFO_DEPTH)) begin errors++; $display("FAIL stall_count_full: got %h want %h", v, 16'(FIFO_DEPTH)); end
        rd16(5'h00, v);
        checks++; if (v !== 16'h0005) begin errors++; $display("FAIL stall_status_full: got %h want 0005", v); end
        v = 16'($urandom);
        m_q.push_back(v);
        fork
            xfer(1'b1, 5'h04, 3'd1, v, rd, rs, ry, n);
            begin
                repeat (4) @(negedge clk);
                #2;
                checks++; if (bus.hreadyout !== 1'b0) begin errors++; $display("FAIL stall_hreadyout: got %b want 0", bus.hreadyout); end
                hold_busy = 1'b0;
            end
        join
        checks++; if (n < 3 || n >= 50) begin errors++; $display("FAIL stall_cycles: got %0d want 3..49", n); end
        for (int c = 0; c < 400 && got_q.size() < 5; c++) @(negedge clk);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL stall_issue_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== m_q[i]) begin errors++; $display("FAIL stall_order[%0d]: got %h want %h", i, got_q[i], m_q[i]); end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_ncs();
        logic [15:0] v;
        got_q.delete(); m_q.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v = 16'($urandom);
            wr16(5'h04, v);
            m_q.push_back(v);
        end
        wr16(5'h06, 16'h0001);
        @(negedge clk);
        checks++; if (new_coefficient_set !== 1'b1) begin errors++; $display("FAIL ncs_set: got %b want 1", new_coefficient_set); end
        hold_busy = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ncs_blocks_issue: got %0d issues want 0", got_q.size()); end
        rd16(5'h00, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL ncs_status_busy: got %h want 0001", v); end
        @(negedge clk); coeff_ack = 1'b1;
        @(negedge clk); coeff_ack = 1'b0;
        checks++; if (new_coefficient_set !== 1'b0) begin errors++; $display("FAIL ncs_cleared: got %b want 0", new_coefficient_set); end
        for (int c = 0; c < 200 && got_q.size() < 2; c++) @(negedge clk);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL ncs_issue_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== m_q[i]) begin errors++; $display("FAIL ncs_order[%0d]: got %h want %h", i, got_q[i], m_q[i]); end
        end
        repeat (10) @(negedge clk);
        coeff_ack = 1'b1;
        wr16(5'h06, 16'h0001);
        @(negedge clk);
        coeff_ack = 1'b0;
        checks++; if (new_coefficient_set !== 1'b1) begin errors++; $display("FAIL ncs_set_beats_ack: got %b want 1", new_coefficient_set); end
        @(negedge clk); coeff_ack = 1'b1;
        @(negedge clk); coeff_ack = 1'b0;
    endtask

    task automatic test_flush();
        logic [15:0] v;
        m_q.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v = 16'($urandom);
            wr16(5'h04, v);
            m_q.push_back(v);
        end
        rd16(5'h04, v);
        checks++; if (v !== m_q[0]) begin errors++; $display("FAIL sample_head_read: got %h want %h", v, m_q[0]); end
        rd16(5'h08, v);
        checks++; if (v !== 16'h0003) begin errors++; $display("FAIL flush_pre_count: got %h want 0003", v); end
        wr16(5'h06, 16'h0002);
        rd16(5'h08, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL flush_count: got %h want 0000", v); end
        rd16(5'h04, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL flush_empty_read: got %h want 0000", v); end
        rd16(5'h00, v);
        checks++; if (v !== 16'h0003) begin errors++; $display("FAIL flush_status: got %h want 0003", v); end
        hold_busy = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        logic [15:0] v, rd; logic [1:0] rs, ry; int n;
        hold_busy = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) wr16(5'h04, 16'($urandom));
        fork
            xfer(1'b1, 5'h04, 3'd1, 16'hBEEF, rd, rs, ry, n);
            begin
                repeat (4) @(negedge clk);
                #2;
                rst = 1'b1;
                #1;
                checks++; if (bus.hreadyout !== 1'b1) begin errors++; $display("FAIL rst_stall_hreadyout: got %b want 1", bus.hreadyout); end
                checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_stall_data_ready: got %b want 0", data_ready); end
            end
        join
        @(negedge clk);
        rst = 1'b0;
        hold_busy = 1'b0;
        for (int k = 0; k < NUM_COEFFS; k++) m_coeff[k] = 16'h0;
        rd16(5'h08, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_stall_count: got %h want 0000", v); end
        coefficient_num = 2'(NUM_COEFFS - 1);
        #1;
        checks++; if (fir_coefficient !== m_coeff[NUM_COEFFS - 1]) begin errors++; $display("FAIL rst_stall_coeff: got %h want %h", fir_coefficient, m_coeff[NUM_COEFFS - 1]); end
    endtask

    initial begin
        test_reset();
        test_status_result();
        test_coeff();
        test_byte_write();
        test_errors();
        test_back_to_back();
        test_fifo_stall();
        test_ncs();
        test_flush();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
